rsa_modexp_core: RTL and testbench

- Modular-exponentiation engine, C = P^E mod M. It sits on the responder side of the RSA enable/reset/end-of-conversion control interface.
- It is driven by the RSA control FSM's en_rsa and rst_rsa outputs and answers with eoc_rsa_unit.
- Uses left-to-right square-and-multiply over a bit-serial interleaved modular multiplier.

---
 rtl/rsa_pkg.sv | 17 +
 rtl/rsa_modmul.sv | 80 ++++++++
 rtl/rsa_modexp_core.sv | 139 +++++++++++++
 tb/tb_rsa_modexp_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rsa_pkg;

    localparam int RSA_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SQUARE,
        MULT,
        NEXT,
        DONE
    } rsa_core_state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier, result = a*b mod m (b < m).
// Latency: done high WIDTH cycles after start; result held until next start or clear.
// Backpressure: en=0 freezes every register; clr/rst clear the unit.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    // One interleaved step: R = 2R + bit*b, then up to two subtractions of m.
    // With R < m and b < m the sum stays below 3m, which fits in WIDTH+2 bits.
    function automatic logic [WIDTH+1:0] mm_step(
        input logic [WIDTH+1:0] r,
        input logic             bit_i,
        input logic [WIDTH-1:0] bv,
        input logic [WIDTH-1:0] mv
    );
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] mx;
        mx = {2'b00, mv};
        t  = (r << 1) + (bit_i ? {2'b00, bv} : '0);
        if (t >= mx) t = t - mx;
        if (t >= mx) t = t - mx;
        return t;
    endfunction

    logic [WIDTH+1:0] r_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    // Operand capture on start, then one multiplier bit per enabled cycle, MSB first.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q    <= '0;
            a_sh   <= '0;
            b_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (en) begin
            if (start) begin
                // The start cycle already consumes a's MSB against the live inputs.
                r_q    <= mm_step('0, a[WIDTH-1], b, m);
                a_sh   <= {a[WIDTH-2:0], 1'b0};
                b_q    <= b;
                m_q    <= m;
                cnt_q  <= CW'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (cnt_q == CW'(WIDTH)) begin
                    busy_q <= 1'b0;
                end else begin
                    r_q   <= mm_step(r_q, a_sh[WIDTH-1], b_q, m_q);
                    a_sh  <= a_sh << 1;
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign done   = busy_q && (cnt_q == CW'(WIDTH));
    assign result = r_q[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_core.sv
// Left-to-right square-and-multiply modular exponentiation, C = P^E mod M.
// Latency: eoc at go+2+sum over bits of (WIDTH+2)+E_i*(WIDTH+1) enabled cycles.
// Backpressure: en=0 freezes all state; rst_core_n=0 aborts. Option macro: RSA_SKIP_LEADING_ZEROS_EN.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rst_core_n,
    input  logic [WIDTH-1:0] plaintext,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] ciphertext,
    output logic             eoc,
    output logic             err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rsa_core_state_t state_q, state_n;

    logic [WIDTH-1:0] p_q, e_q, m_q, c_q;
    logic [IW-1:0]    idx_q;
    logic             err_q;
    logic             started_q;

    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_result;
    logic             op_bad;
    logic [IW-1:0]    nidx;
    logic             skip_sq;
    rsa_core_state_t  bit_entry;

    assign op_bad = (m_q < WIDTH'(2)) || (p_q >= m_q);
    assign mul_b  = (state_q == SQUARE) ? c_q : p_q;

    // Bit index the next SQUARE would operate on, and whether it can be skipped.
    assign nidx = (state_q == CHECK) ? idx_q : idx_q - IW'(1);
`ifdef RSA_SKIP_LEADING_ZEROS_EN
    assign skip_sq = ((e_q >> nidx) == '0);
`else
    assign skip_sq = 1'b0;
`endif
    assign bit_entry = skip_sq ? NEXT : SQUARE;

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk    (clk),
        .rst    (rst),
        .clr    (!rst_core_n),
        .en     (en),
        .start  (mul_start),
        .a      (c_q),
        .b      (mul_b),
        .m      (m_q),
        .result (mul_result),
        .done   (mul_done)
    );

    // State register: hard reset and controller soft reset both return to IDLE.
    always_ff @(posedge clk) begin
        if (rst || !rst_core_n) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_n;
        end
    end

    // Next-state decode.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    state_n = CHECK;
            CHECK:   begin
                if (op_bad || (e_q == '0)) state_n = DONE;
                else                       state_n = bit_entry;
            end
            SQUARE:  if (mul_done) state_n = e_q[idx_q] ? MULT : NEXT;
            MULT:    if (mul_done) state_n = NEXT;
            NEXT:    state_n = (idx_q == '0) ? DONE : bit_entry;
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs: multiplier kick on entry to SQUARE/MULT, results exposed only in DONE.
    always_comb begin
        mul_start  = ((state_q == SQUARE) || (state_q == MULT)) && !started_q;
        eoc        = (state_q == DONE);
        ciphertext = (state_q == DONE) ? c_q : '0;
        err        = (state_q == DONE) ? err_q : 1'b0;
    end

    // Datapath: operand latch at go, accumulator updates, bit index walk.
    always_ff @(posedge clk) begin
        if (rst || !rst_core_n) begin
            p_q       <= '0;
            e_q       <= '0;
            m_q       <= '0;
            c_q       <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            started_q <= 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    p_q   <= plaintext;
                    e_q   <= exponent;
                    m_q   <= modulus;
                    c_q   <= WIDTH'(1);
                    idx_q <= IW'(WIDTH - 1);
                    err_q <= 1'b0;
                end
                CHECK: begin
                    if (op_bad) begin
                        c_q   <= '0;
                        err_q <= 1'b1;
                    end
                end
                SQUARE, MULT: begin
                    if (mul_start) started_q <= 1'b1;
                    if (mul_done) begin
                        c_q       <= mul_result;
                        started_q <= 1'b0;
                    end
                end
                NEXT: begin
                    if (idx_q != '0) idx_q <= idx_q - IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
module tb_rsa_modexp_core;

    localparam int W = 8;

`ifdef RSA_SKIP_LEADING_ZEROS_EN
    localparam int LAT_BASIC = 46;
    localparam int FREEZE_AT = 8;
    localparam int ABORT_AT  = 38;
`else
    localparam int LAT_BASIC = 100;
    localparam int FREEZE_AT = 4;
    localparam int ABORT_AT  = 55;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         rst_core_n;
    logic [W-1:0] plaintext, exponent, modulus;
    logic [W-1:0] ciphertext;
    logic         eoc;
    logic         err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] e;
        logic [W-1:0] m;
        logic [W-1:0] c;
        logic         err;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] c;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    rsa_modexp_core #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rst_core_n (rst_core_n),
        .plaintext  (plaintext),
        .exponent   (exponent),
        .modulus    (modulus),
        .ciphertext (ciphertext),
        .eoc        (eoc),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic int ref_modexp(input int p, input int e, input int m);
        longint r = 1;
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * p) % m;
        end
        return int'(r);
    endfunction

    function automatic int lat_model(input int e);
        int s;
        if (e == 0) return 2;
        s = 2;
        for (int i = W - 1; i >= 0; i--) begin
`ifdef RSA_SKIP_LEADING_ZEROS_EN
            if ((e >> i) == 0) begin
                s += 1;
                continue;
            end
`endif
            s += (W + 2) + (e[i] ? (W + 1) : 0);
        end
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Clear, present operands, release, then wait for eoc; optional en freeze window.
    task automatic run_one(input string name, input logic [W-1:0] p, input logic [W-1:0] e,
                           input logic [W-1:0] m, input exp_t ex, input int fa, input int fl);
        int   lat;
        exp_t got;
        rst_core_n = 1'b0;
        en         = 1'b1;
        plaintext  = p;
        exponent   = e;
        modulus    = m;
        @(posedge clk); #1;
        rst_core_n = 1'b1;
        ex.lat     = ex.lat + fl;
        sb.push_back(ex);
        @(posedge clk); #1;
        lat = 1;
        plaintext = W'($urandom);
        exponent  = W'($urandom);
        modulus   = W'($urandom);
        while (!eoc && lat < 3000) begin
            en = !(lat >= fa && lat < fa + fl);
            @(posedge clk); #1;
            lat++;
        end
        en  = 1'b1;
        got = sb.pop_front();
        if (!eoc) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: eoc=0 after %0d cycles, expected by %0d", name, lat, got.lat);
        end else begin
            chk({name, " ciphertext"}, int'(ciphertext), int'(got.c));
            chk({name, " err"},        int'(err),        int'(got.err));
            chk({name, " latency"},    lat,              got.lat);
        end
    endtask

    initial begin
        exp_t ex;
        logic [W-1:0] rp, re, rm;

        vecs[0] = '{8'd4,   8'd3,   8'd11,  8'd9,   1'b0, LAT_BASIC};
        vecs[1] = '{8'd7,   8'd13,  8'd33,  8'd13,  1'b0, lat_model(13)};
        vecs[2] = '{8'd5,   8'd0,   8'd33,  8'd1,   1'b0, 2};
        vecs[3] = '{8'd0,   8'd5,   8'd1,   8'd0,   1'b1, 2};
        vecs[4] = '{8'd40,  8'd3,   8'd33,  8'd0,   1'b1, 2};
        vecs[5] = '{8'd33,  8'd7,   8'd33,  8'd0,   1'b1, 2};
        vecs[6] = '{8'd0,   8'd5,   8'd7,   8'd0,   1'b0, lat_model(5)};
        vecs[7] = '{8'd32,  8'd1,   8'd33,  8'd32,  1'b0, lat_model(1)};
        vecs[8] = '{8'd254, 8'd2,   8'd255, 8'd1,   1'b0, lat_model(2)};
        vecs[9] = '{8'd1,   8'd255, 8'd2,   8'd1,   1'b0, lat_model(255)};

        rst        = 1'b1;
        en         = 1'b1;
        rst_core_n = 1'b0;
        plaintext  = '0;
        exponent   = '0;
        modulus    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset eoc",        int'(eoc),        0);
        chk("reset ciphertext", int'(ciphertext), 0);
        chk("reset err",        int'(err),        0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            ex = '{vecs[i].c, vecs[i].err, vecs[i].lat};
            run_one($sformatf("vec%0d", i), vecs[i].p, vecs[i].e, vecs[i].m, ex, 0, 0);
        end

        // DONE holds, then soft clear empties the outputs on the next cycle.
        ex = '{8'd9, 1'b0, LAT_BASIC};
        run_one("hold", 8'd4, 8'd3, 8'd11, ex, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("hold eoc",        int'(eoc),        1);
        chk("hold ciphertext", int'(ciphertext), 9);
        rst_core_n = 1'b0;
        @(posedge clk); #1;
        chk("clear eoc",        int'(eoc),        0);
        chk("clear ciphertext", int'(ciphertext), 0);

        // en freeze during a square step stretches latency one-for-one.
        ex = '{8'd13, 1'b0, lat_model(13)};
        run_one("freeze", 8'd7, 8'd13, 8'd33, ex, FREEZE_AT, 5);

        // Abort mid-MULT, then a clean run must be unaffected.
        rst_core_n = 1'b0;
        plaintext  = 8'd7;
        exponent   = 8'd13;
        modulus    = 8'd33;
        @(posedge clk); #1;
        rst_core_n = 1'b1;
        repeat (ABORT_AT) @(posedge clk);
        #1;
        rst_core_n = 1'b0;
        @(posedge clk); #1;
        chk("abort eoc",        int'(eoc),        0);
        chk("abort ciphertext", int'(ciphertext), 0);
        ex = '{8'd9, 1'b0, LAT_BASIC};
        run_one("after_abort", 8'd4, 8'd3, 8'd11, ex, 0, 0);

        // Hard reset while in DONE with err set.
        ex = '{8'd0, 1'b1, 2};
        run_one("err_done", 8'd3, 8'd3, 8'd1, ex, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst eoc",        int'(eoc),        0);
        chk("rst ciphertext", int'(ciphertext), 0);
        chk("rst err",        int'(err),        0);
        rst = 1'b0;

        // Random sweep against the reference model.
        for (int k = 0; k < 25; k++) begin
            rm = W'($urandom_range(2, 255));
            rp = W'($urandom_range(0, int'(rm) - 1));
            re = W'($urandom_range(0, 255));
            ex = '{W'(ref_modexp(int'(rp), int'(re), int'(rm))), 1'b0, lat_model(int'(re))};
            run_one($sformatf("rand%0d p=%0d e=%0d m=%0d", k, rp, re, rm), rp, re, rm, ex, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
